line_fill_engine: RTL

- Sits directly upstream of axi_driver, between the cache controller and the driver's single-beat request front-end.
- Converts one cache-line command (fill, writeback, or writeback-then-fill) into a sequence of single-beat driver requests, one at a time.
- Assembles returned read beats into a full line for the cache.

---
 rtl/line_fill_pkg.sv | 33 +++
 rtl/beat_addr_gen.sv | 24 ++
 rtl/line_fill_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_pkg.sv
// Shared types and size helpers for the cache line fill/writeback engine.
// The critical-word-first fill order is enabled with LINE_FILL_CRITICAL_WORD_FIRST_EN.
package line_fill_pkg;

    typedef enum logic [1:0] {
        OP_FILL         = 2'd0,
        OP_WB           = 2'd1,
        OP_WB_THEN_FILL = 2'd2,
        OP_RSVD         = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_WB_WAIT,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_DONE
    } state_e;

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int beats(input int line_bytes, input int data_width);
        return line_bytes / (data_width / 8);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beat_addr_gen.sv
// Line base plus beat index to beat address, with an optional wrap start.
// Purely combinational; the index wraps inside the line so no carry leaves it.
module beat_addr_gen
    import line_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BYTES = 64,
    localparam int IDX_W = idx_width(beats(LINE_BYTES, DATA_WIDTH))
) (
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [IDX_W-1:0]      start_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [IDX_W-1:0]      idx_abs_o
);

    localparam int BEATS    = beats(LINE_BYTES, DATA_WIDTH);
    localparam int BEAT_OFF = $clog2(bytes_per_beat(DATA_WIDTH));

    assign idx_abs_o = (BEATS > 1) ? idx_i + start_i : '0;
    assign addr_o    = base_i | (ADDR_WIDTH'(idx_abs_o) << BEAT_OFF);

endmodule

// File: rtl/line_fill_engine.sv
// Turns one cache-line command into single-beat driver requests, one in flight.
// LINE_FILL_CRITICAL_WORD_FIRST_EN starts fills at the beat holding the fill address.
module line_fill_engine
    import line_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BYTES = 64
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [ADDR_WIDTH-1:0]     cmd_fill_addr,
    input  logic [ADDR_WIDTH-1:0]     cmd_wb_addr,
    input  logic [LINE_BYTES*8-1:0]   cmd_wb_line,
    output logic                      done_valid,
    output logic                      done_err,
    output logic [LINE_BYTES*8-1:0]   fill_line,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic                      req_is_write,
    output logic [ADDR_WIDTH-1:0]     req_addr,
    output logic [7:0]                req_len,
    output logic [2:0]                req_size,
    output logic [DATA_WIDTH-1:0]     req_wdata,
    output logic [DATA_WIDTH/8-1:0]   req_wstrb,
    input  logic                      rsp_valid,
    input  logic                      rsp_is_write,
    input  logic                      rsp_err,
    input  logic [DATA_WIDTH-1:0]     rsp_rdata
);

    localparam int BPB    = bytes_per_beat(DATA_WIDTH);
    localparam int BEATS  = beats(LINE_BYTES, DATA_WIDTH);
    localparam int IDX_W  = idx_width(BEATS);
    localparam int LINE_W = LINE_BYTES * 8;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~(ADDR_WIDTH'(LINE_BYTES - 1));
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BEATS - 1);

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [ADDR_WIDTH-1:0]   fill_base_q, fill_base_d;
    logic [ADDR_WIDTH-1:0]   wb_base_q, wb_base_d;
    logic [LINE_W-1:0]       wb_line_q, wb_line_d;
    logic [LINE_W-1:0]       fill_line_q, fill_line_d;
    logic [IDX_W-1:0]        beat_q, beat_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic                    wb_phase;
    logic [IDX_W-1:0]        fill_start;
    logic [ADDR_WIDTH-1:0]   gen_base;
    logic [IDX_W-1:0]        gen_start;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic [IDX_W-1:0]        beat_abs;

    assign accept = cmd_valid && cmd_ready;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0] start_q, start_d;

    always_comb begin
        start_d = start_q;
        if (accept) begin
            start_d = IDX_W'(cmd_fill_addr >> $clog2(BPB));
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            start_q <= '0;
        end else begin
            start_q <= start_d;
        end
    end

    assign fill_start = start_q;
`else
    assign fill_start = '0;
`endif

    // Writebacks always walk the line from beat 0.
    assign wb_phase  = (state_q == S_WB_REQ) || (state_q == S_WB_WAIT);
    assign gen_base  = wb_phase ? wb_base_q : fill_base_q;
    assign gen_start = wb_phase ? '0 : fill_start;

    beat_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_BYTES (LINE_BYTES)
    ) u_addr_gen (
        .base_i    (gen_base),
        .idx_i     (beat_q),
        .start_i   (gen_start),
        .addr_o    (beat_addr),
        .idx_abs_o (beat_abs)
    );

    assign cmd_ready    = (state_q == S_IDLE);
    assign done_valid   = (state_q == S_DONE);
    assign done_err     = done_valid && err_q;
    assign fill_line    = fill_line_q;
    assign req_valid    = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ);
    assign req_is_write = (state_q == S_WB_REQ);
    assign req_addr     = beat_addr;
    assign req_len      = '0;
    assign req_size     = 3'($clog2(BPB));
    assign req_wdata    = wb_line_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH];
    assign req_wstrb    = '1;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fill_base_d = fill_base_q;
        wb_base_d   = wb_base_q;
        wb_line_d   = wb_line_q;
        fill_line_d = fill_line_q;
        beat_d      = beat_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d        = op_e'(cmd_op);
                    fill_base_d = cmd_fill_addr & LINE_MASK;
                    wb_base_d   = cmd_wb_addr & LINE_MASK;
                    wb_line_d   = cmd_wb_line;
                    beat_d      = '0;
                    err_d       = 1'b0;
                    case (op_e'(cmd_op))
                        OP_FILL:         state_d = S_FILL_REQ;
                        OP_WB,
                        OP_WB_THEN_FILL: state_d = S_WB_REQ;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_WB_REQ: begin
                if (req_ready) state_d = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (rsp_valid) begin
                    err_d = err_q | rsp_err | ~rsp_is_write;
                    if (beat_q == LAST) begin
                        beat_d  = '0;
                        state_d = (op_q == OP_WB_THEN_FILL) ? S_FILL_REQ
                                                            : S_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = S_WB_REQ;
                    end
                end
            end
            S_FILL_REQ: begin
                if (req_ready) state_d = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (rsp_valid) begin
                    fill_line_d[int'(beat_abs)*DATA_WIDTH +: DATA_WIDTH] =
                        rsp_rdata;
                    err_d = err_q | rsp_err | rsp_is_write;
                    if (beat_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = S_FILL_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            op_q        <= OP_FILL;
            fill_base_q <= '0;
            wb_base_q   <= '0;
            wb_line_q   <= '0;
            fill_line_q <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fill_base_q <= fill_base_d;
            wb_base_q   <= wb_base_d;
            wb_line_q   <= wb_line_d;
            fill_line_q <= fill_line_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
        end
    end

endmodule
